// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bundle between fetch_ctrl and imem.
// master: fetch side (drives request). slave: memory side (drives response).
interface fetch_ctrl_if;
   logic        imem_req;
   logic [63:0] imem_addr_F;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr_F,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr_F,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one imem request at a time,
// holds the returned instruction until decode takes it, and applies branch
// redirects, including ones that land while a request is outstanding.
// Optional feature macro: FETCH_PERF_EN adds saturating performance counters
// (perf_fetched, perf_wait, perf_squash).
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | just out of reset, no request yet
// REQ   | imem_req high, waiting for imem_ack at address pc
// VALID | instr_F/pc_F presented to decode, waiting for acceptance
module fetch_ctrl #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter logic [63:0] PC_STEP  = 64'd4
`ifdef FETCH_PERF_EN
   ,
   parameter int          CNT_W    = 32
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              PCSrc_F,
   input  logic [63:0]       PCBranch_F,
   input  logic              stall_F,
   fetch_ctrl_if.master      imem,
   output logic [31:0]       instr_F,
   output logic              instr_valid_F,
   output logic [63:0]       pc_F
`ifdef FETCH_PERF_EN
   ,
   output logic [CNT_W-1:0]  perf_fetched,
   output logic [CNT_W-1:0]  perf_wait,
   output logic [CNT_W-1:0]  perf_squash
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      VALID = 2'd2
   } state_t;

   state_t      state;
   logic [63:0] pc;
   logic [63:0] tgt;
   logic        redir_pend;
   logic        req_q;

   // Address comes straight from the PC register so it is stable for the
   // whole request; the PC only moves on the ack edge or when leaving VALID.
   assign imem.imem_addr_F = pc;
   assign imem.imem_req    = req_q;

   // Main sequencer. A redirect seen during a request is parked in tgt and
   // applied when the ack arrives; a redirect on the ack cycle itself wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         pc            <= RESET_PC;
         tgt           <= '0;
         redir_pend    <= 1'b0;
         req_q         <= 1'b0;
         instr_F       <= '0;
         pc_F          <= '0;
         instr_valid_F <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= REQ;
               req_q <= 1'b1;
            end
            REQ: begin
               if (imem.imem_ack) begin
                  if (redir_pend || PCSrc_F) begin
                     pc         <= PCSrc_F ? PCBranch_F : tgt;
                     redir_pend <= 1'b0;
                  end else begin
                     instr_F       <= imem.imem_rdata;
                     pc_F          <= pc;
                     instr_valid_F <= 1'b1;
                     req_q         <= 1'b0;
                     state         <= VALID;
                  end
               end else if (PCSrc_F) begin
                  redir_pend <= 1'b1;
                  tgt        <= PCBranch_F;
               end
            end
            VALID: begin
               if (PCSrc_F) begin
                  instr_valid_F <= 1'b0;
                  pc            <= PCBranch_F;
                  req_q         <= 1'b1;
                  state         <= REQ;
               end else if (!stall_F) begin
                  instr_valid_F <= 1'b0;
                  pc            <= pc + PC_STEP;
                  req_q         <= 1'b1;
                  state         <= REQ;
               end
            end
            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic ev_fetched;
   logic ev_wait;
   logic ev_squash;

   assign ev_fetched = (state == VALID) && !stall_F && !PCSrc_F;
   assign ev_wait    = (state == REQ) && !imem.imem_ack;
   assign ev_squash  = ((state == REQ) && imem.imem_ack && (redir_pend || PCSrc_F))
                     || ((state == VALID) && PCSrc_F);

   // Saturating event counters; they stick at all-ones rather than wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_fetched <= '0;
         perf_wait    <= '0;
         perf_squash  <= '0;
      end else begin
         if (ev_fetched && !(&perf_fetched)) perf_fetched <= perf_fetched + 1'b1;
         if (ev_wait    && !(&perf_wait))    perf_wait    <= perf_wait + 1'b1;
         if (ev_squash  && !(&perf_squash))  perf_squash  <= perf_squash + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a vector table covers sequential fetch,
// stall hold, in-flight and same-cycle redirects and ack-outside-REQ;
// hand sequences cover reset mid-request and PC wrap-around.
module tb_fetch_ctrl;

   logic        clk;
   logic        reset;
   logic        PCSrc_F;
   logic [63:0] PCBranch_F;
   logic        stall_F;
   logic [31:0] instr_F;
   logic        instr_valid_F;
   logic [63:0] pc_F;

   logic [31:0] instr_F_w;
   logic        instr_valid_F_w;
   logic [63:0] pc_F_w;

   fetch_ctrl_if u_if ();
   fetch_ctrl_if u_if_w ();

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_wait, perf_squash;
   logic [31:0] perf_fetched_w, perf_wait_w, perf_squash_w;
`endif

   fetch_ctrl u_dut (
      .clk           (clk),
      .reset         (reset),
      .PCSrc_F       (PCSrc_F),
      .PCBranch_F    (PCBranch_F),
      .stall_F       (stall_F),
      .imem          (u_if.master),
      .instr_F       (instr_F),
      .instr_valid_F (instr_valid_F),
      .pc_F          (pc_F)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched  (perf_fetched),
      .perf_wait     (perf_wait),
      .perf_squash   (perf_squash)
`endif
   );

   fetch_ctrl #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_dut_wrap (
      .clk           (clk),
      .reset         (reset),
      .PCSrc_F       (1'b0),
      .PCBranch_F    (64'h0),
      .stall_F       (1'b0),
      .imem          (u_if_w.master),
      .instr_F       (instr_F_w),
      .instr_valid_F (instr_valid_F_w),
      .pc_F          (pc_F_w)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched  (perf_fetched_w),
      .perf_wait     (perf_wait_w),
      .perf_squash   (perf_squash_w)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        pcsrc;
      logic [63:0] br;
      logic        stall;
      logic        ack;
      logic [31:0] rdata;
      logic        exp_req;
      logic [63:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_instr;
      logic [63:0] exp_pc;
   } vec_t;

   localparam int NV = 26;
   vec_t vecs[NV];

   function automatic vec_t mk(logic pcsrc, logic [63:0] br, logic stall, logic ack,
                               logic [31:0] rdata, logic ereq, logic [63:0] eaddr,
                               logic evalid, logic [31:0] einstr, logic [63:0] epc);
      vec_t v;
      v.pcsrc = pcsrc; v.br = br; v.stall = stall; v.ack = ack; v.rdata = rdata;
      v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = evalid;
      v.exp_instr = einstr; v.exp_pc = epc;
      return v;
   endfunction

   localparam logic [31:0] I0 = 32'hF800_0001;

   initial begin
      //            pcsrc br       stall ack rdata          req addr     vld instr         pc
      vecs[0]  = mk(0, 64'h0,   0, 0, 32'h0,         1, 64'h0,   0, 32'h0,         64'h0);
      vecs[1]  = mk(0, 64'h0,   0, 1, I0,            0, 64'h0,   1, I0,            64'h0);
      vecs[2]  = mk(0, 64'h0,   0, 0, 32'h0,         1, 64'h4,   0, 32'h0,         64'h0);
      vecs[3]  = mk(0, 64'h0,   0, 1, I0,            0, 64'h4,   1, I0,            64'h4);
      vecs[4]  = mk(0, 64'h0,   0, 0, 32'h0,         1, 64'h8,   0, 32'h0,         64'h0);
      vecs[5]  = mk(0, 64'h0,   0, 1, I0,            0, 64'h8,   1, I0,            64'h8);
      vecs[6]  = mk(0, 64'h0,   1, 0, 32'h0,         0, 64'h8,   1, I0,            64'h8);
      vecs[7]  = mk(0, 64'h0,   1, 0, 32'h0,         0, 64'h8,   1, I0,            64'h8);
      vecs[8]  = mk(0, 64'h0,   1, 0, 32'h0,         0, 64'h8,   1, I0,            64'h8);
      vecs[9]  = mk(0, 64'h0,   1, 0, 32'h0,         0, 64'h8,   1, I0,            64'h8);
      vecs[10] = mk(0, 64'h0,   1, 0, 32'h0,         0, 64'h8,   1, I0,            64'h8);
      vecs[11] = mk(0, 64'h0,   0, 0, 32'h0,         1, 64'hC,   0, 32'h0,         64'h0);
      vecs[12] = mk(0, 64'h0,   0, 0, 32'h0,         1, 64'hC,   0, 32'h0,         64'h0);
      vecs[13] = mk(1, 64'h100, 0, 0, 32'h0,         1, 64'hC,   0, 32'h0,         64'h0);
      vecs[14] = mk(0, 64'h0,   0, 0, 32'h0,         1, 64'hC,   0, 32'h0,         64'h0);
      vecs[15] = mk(0, 64'h0,   0, 1, 32'hDEADBEEF,  1, 64'h100, 0, 32'h0,         64'h0);
      vecs[16] = mk(0, 64'h0,   0, 1, 32'h13,        0, 64'h100, 1, 32'h13,        64'h100);
      vecs[17] = mk(0, 64'h0,   1, 0, 32'h0,         0, 64'h100, 1, 32'h13,        64'h100);
      vecs[18] = mk(1, 64'h40,  1, 0, 32'h0,         1, 64'h40,  0, 32'h0,         64'h0);
      vecs[19] = mk(0, 64'h0,   0, 1, 32'h1111_1111, 0, 64'h40,  1, 32'h1111_1111, 64'h40);
      vecs[20] = mk(0, 64'h0,   0, 0, 32'h0,         1, 64'h44,  0, 32'h0,         64'h0);
      vecs[21] = mk(1, 64'h200, 0, 0, 32'h0,         1, 64'h44,  0, 32'h0,         64'h0);
      vecs[22] = mk(1, 64'h300, 0, 1, 32'hDEADBEEF,  1, 64'h300, 0, 32'h0,         64'h0);
      vecs[23] = mk(0, 64'h0,   0, 1, 32'h22,        0, 64'h300, 1, 32'h22,        64'h300);
      vecs[24] = mk(0, 64'h0,   1, 1, 32'h99,        0, 64'h300, 1, 32'h22,        64'h300);
      vecs[25] = mk(0, 64'h0,   0, 0, 32'h0,         1, 64'h304, 0, 32'h0,         64'h0);

      reset            = 1'b0;
      PCSrc_F          = 1'b0;
      PCBranch_F       = 64'h0;
      stall_F          = 1'b0;
      u_if.imem_ack    = 1'b0;
      u_if.imem_rdata  = 32'h0;
      u_if_w.imem_ack  = 1'b0;
      u_if_w.imem_rdata = 32'h0;

      repeat (2) @(negedge clk);
      chk("rst_req",   {63'h0, u_if.imem_req}, 64'h0);
      chk("rst_valid", {63'h0, instr_valid_F}, 64'h0);
      chk("rst_instr", {32'h0, instr_F}, 64'h0);
      chk("rst_pc_F",  pc_F, 64'h0);
      chk("rst_addr",  u_if.imem_addr_F, 64'h0);

      reset = 1'b1;
      for (int i = 0; i < NV; i++) begin
         PCSrc_F         = vecs[i].pcsrc;
         PCBranch_F      = vecs[i].br;
         stall_F         = vecs[i].stall;
         u_if.imem_ack   = vecs[i].ack;
         u_if.imem_rdata = vecs[i].rdata;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_req", i),   {63'h0, u_if.imem_req}, {63'h0, vecs[i].exp_req});
         chk($sformatf("v%0d_addr", i),  u_if.imem_addr_F, vecs[i].exp_addr);
         chk($sformatf("v%0d_valid", i), {63'h0, instr_valid_F}, {63'h0, vecs[i].exp_valid});
         if (vecs[i].exp_valid) begin
            chk($sformatf("v%0d_instr", i), {32'h0, instr_F}, {32'h0, vecs[i].exp_instr});
            chk($sformatf("v%0d_pc_F", i),  pc_F, vecs[i].exp_pc);
         end
         @(negedge clk);
      end
      PCSrc_F = 1'b0; stall_F = 1'b0; u_if.imem_ack = 1'b0; u_if.imem_rdata = 32'h0;

      // Reset mid-request: req must drop without waiting for a clock edge.
      chk("mid_req_before", {63'h0, u_if.imem_req}, 64'h1);
      #2 reset = 1'b0;
      #1;
      chk("mid_req_async",   {63'h0, u_if.imem_req}, 64'h0);
      chk("mid_req_async_w", {63'h0, u_if_w.imem_req}, 64'h0);
`ifdef FETCH_PERF_EN
      chk("perf_fetched_rst", {32'h0, perf_fetched}, 64'h0);
      chk("perf_wait_rst",    {32'h0, perf_wait}, 64'h0);
      chk("perf_squash_rst",  {32'h0, perf_squash}, 64'h0);
`endif
      @(negedge clk);
      u_if.imem_ack   = 1'b1;
      u_if.imem_rdata = 32'hBAD0_BAD0;
      @(posedge clk);
      #1;
      chk("rst_ack_valid", {63'h0, instr_valid_F}, 64'h0);
      @(negedge clk);
      u_if.imem_ack = 1'b0;
      reset         = 1'b1;
      @(posedge clk);
      #1;
      chk("restart_req",   {63'h0, u_if.imem_req}, 64'h1);
      chk("restart_addr",  u_if.imem_addr_F, 64'h0);
      chk("restart_valid", {63'h0, instr_valid_F}, 64'h0);
      chk("wrap_req",      {63'h0, u_if_w.imem_req}, 64'h1);
      chk("wrap_addr0",    u_if_w.imem_addr_F, 64'hFFFF_FFFF_FFFF_FFFC);

      // PC wrap: accept one instruction at the top of the address space.
      @(negedge clk);
      u_if_w.imem_ack   = 1'b1;
      u_if_w.imem_rdata = 32'hABCD_0001;
      @(posedge clk);
      #1;
      chk("wrap_valid", {63'h0, instr_valid_F_w}, 64'h1);
      chk("wrap_instr", {32'h0, instr_F_w}, 64'hABCD_0001);
      chk("wrap_pc_F",  pc_F_w, 64'hFFFF_FFFF_FFFF_FFFC);
      @(negedge clk);
      u_if_w.imem_ack = 1'b0;
      @(posedge clk);
      #1;
      chk("wrap_next_req",  {63'h0, u_if_w.imem_req}, 64'h1);
      chk("wrap_next_addr", u_if_w.imem_addr_F, 64'h0);
      chk("wrap_next_vld",  {63'h0, instr_valid_F_w}, 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
